// File: rtl/umai_mem_responder.sv
// Memory-backed UMAI target: serialises write/read burst commands onto one
// 512-bit single-port array and streams read beats back with backpressure.
module umai_mem_responder #(
    parameter int Depth = 1024,
    parameter int AddrW = $clog2(Depth)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wcmd_valid,
    output logic         o_wcmd_ready,
    input  logic [31:0]  i_wcmd_addr,
    input  logic [5:0]   i_wcmd_len,
    input  logic         i_rcmd_valid,
    output logic         o_rcmd_ready,
    input  logic [31:0]  i_rcmd_addr,
    input  logic [5:0]   i_rcmd_len,
    input  logic         i_wvalid,
    output logic         o_wready,
    input  logic [511:0] i_wdata,
    output logic         o_rvalid,
    input  logic         i_rready,
    output logic [511:0] o_rdata,
    output logic         o_busy
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

    state_e           state_q;
    logic [AddrW-1:0] idx_q, idx_d;
    logic [6:0]       cnt_q;      // beats left to complete (write beats / read handshakes)
    logic [6:0]       iss_q;      // read beats not yet issued to the array
    logic             lww_q;
    logic             rvalid_q;
    logic [511:0]     rdata_q;
    logic [511:0]     mem [Depth];

    logic idle, pick_w, pick_r, wbeat, rd_issue, rd_hs;

    // Ready is held low while reset is asserted even though the FSM sits in IDLE.
    assign idle     = (state_q == IDLE) && i_rst_n;
    assign pick_w   = i_wcmd_valid && (!i_rcmd_valid || !lww_q);
    assign pick_r   = i_rcmd_valid && (!i_wcmd_valid || lww_q);
    assign o_wcmd_ready = idle && pick_w;
    assign o_rcmd_ready = idle && pick_r;

    assign idx_d    = idx_q + AddrW'(1);
    assign wbeat    = (state_q == WRITE) && i_wvalid;
    assign rd_issue = (state_q == READ) && (iss_q != 7'd0) && (!rvalid_q || i_rready);
    assign rd_hs    = rvalid_q && i_rready;

    assign o_wready = (state_q == WRITE);
    assign o_busy   = (state_q != IDLE);
    assign o_rvalid = rvalid_q;
    assign o_rdata  = rdata_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_wcmd_addr[31:AddrW+6], i_wcmd_addr[5:0],
                                i_rcmd_addr[31:AddrW+6], i_rcmd_addr[5:0]};

    always_ff @(posedge i_clk) begin
        if (wbeat) mem[idx_q] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            iss_q    <= '0;
            lww_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (o_wcmd_ready) begin
                        state_q <= WRITE;
                        idx_q   <= i_wcmd_addr[AddrW+5:6];
                        cnt_q   <= 7'(i_wcmd_len) + 7'd1;
                        lww_q   <= 1'b1;
                    end else if (o_rcmd_ready) begin
                        state_q <= READ;
                        idx_q   <= i_rcmd_addr[AddrW+5:6];
                        cnt_q   <= 7'(i_rcmd_len) + 7'd1;
                        iss_q   <= 7'(i_rcmd_len) + 7'd1;
                        lww_q   <= 1'b0;
                    end
                end
                WRITE: begin
                    if (i_wvalid) begin
                        idx_q <= idx_d;
                        cnt_q <= cnt_q - 7'd1;
                        if (cnt_q == 7'd1) state_q <= IDLE;
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        rdata_q  <= mem[idx_q];
                        rvalid_q <= 1'b1;
                        idx_q    <= idx_d;
                        iss_q    <= iss_q - 7'd1;
                    end else if (rd_hs) begin
                        rvalid_q <= 1'b0;
                    end
                    if (rd_hs) begin
                        cnt_q <= cnt_q - 7'd1;
                        if (cnt_q == 7'd1) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/umai_mem_responder.md
# umai_mem_responder

Memory-backed UMAI responder that terminates the UMAI master interface of the AIB top level (its `o_umai_mst_*` / `i_umai_mst_*` ports). It accepts write and read burst commands, stores write beats in an internal single-port 512-bit-wide array, and returns read beats with valid/ready backpressure. It serves as the far-end target for chiplet loopback and bring-up.

## Interface

Parameters:
- `Depth`, 1024: number of 512-bit words; power of two, minimum 2.
- `AddrW`, $clog2(Depth): width of the internal word index.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst_n`, in, 1: reset; asynchronous, active-low.
- `i_wcmd_valid` in 1, `o_wcmd_ready` out 1, `i_wcmd_addr` in 32, `i_wcmd_len` in 6: write command channel.
- `i_rcmd_valid` in 1, `o_rcmd_ready` out 1, `i_rcmd_addr` in 32, `i_rcmd_len` in 6: read command channel.
- `i_wvalid` in 1, `o_wready` out 1, `i_wdata` in 512: write data channel.
- `o_rvalid` out 1, `i_rready` in 1, `o_rdata` out 512: read data channel.
- `o_busy`, out, 1: high whenever the block is not in IDLE.

## Operation

- Address mapping:
  - Byte address; `addr[5:0]` is ignored.
  - Word index = `addr[AddrW+5:6]`; higher bits are ignored.
  - Burst length in beats = `len + 1` (range 1..64).
  - The index increments per beat modulo `Depth`, so bursts wrap around the array.
- FSM states: IDLE, WRITE, READ. Exactly one burst is in flight at any time.
- IDLE:
  - `o_wcmd_ready` and `o_rcmd_ready` are combinational from state and arbitration; both are 0 outside IDLE.
  - At most one command is accepted per cycle.
- Arbitration when both command valids are high: round-robin using a `last_was_write` flag. Reset value of the flag is 0, so write wins the first tie. A lone valid command is always accepted.
- Command accept latches the base index and the beat count, then moves to WRITE or READ.
- WRITE:
  - `o_wready` = 1.
  - Each `i_wvalid && o_wready` beat writes `mem[idx]`, then increments `idx` and decrements `cnt`.
  - The beat with `cnt == 1` completes the burst; go to IDLE.
- READ:
  - A read is issued when `issued < beats` and (`!o_rvalid || i_rready`).
  - The array is synchronous: data is registered into `o_rdata`, and `o_rvalid` rises on the next cycle.
  - When no read is issued, `o_rvalid` falls only after a handshake.
  - Return to IDLE in the cycle after the last beat's `o_rvalid && i_rready` handshake.
- Ordering: commands are strictly serialised, so a read following a write to the same address returns the new data.
- Write beats presented while in IDLE or READ are not accepted (`o_wready` = 0). They wait with no loss of data.

## Timing

- Reset values:
  - All ready and valid outputs are 0; `o_busy` = 0; `o_rdata` = 0.
  - FSM is IDLE; counters and `last_was_write` are 0.
  - Array contents are not reset.
- Reset asserted mid-burst: all state and outputs return to reset values immediately. Partially written bursts leave the already-written words in the array.
- Write: command accepted at cycle N; `o_wready` = 1 from N+1. Throughput is 1 beat/cycle. IDLE is entered at L+1, where L is the last beat, and `o_*cmd_ready` can be high at L+1.
- Read: command accepted at N; first read issued at N+1; `o_rvalid` = 1 at N+2. Throughput is 1 beat/cycle while `i_rready` = 1.
- `o_rdata` holds stable while `o_rvalid && !i_rready`.
- Read turnaround: last handshake at cycle L; `o_rvalid` = 0 and state IDLE at L+1.

## Test plan

- Single-beat write of `0xA5…A5` to addr `0x40` (len 0), then read addr `0x40` len 0 -> `o_rvalid` 2 cycles after rcmd accept, `o_rdata` = `0xA5…A5`, `o_busy` low after the handshake.
- 64-beat write (len 63) of data = beat number at addr `(Depth-4)*64`, then 64-beat read -> beats 0..3 land at indices Depth-4..Depth-1, beats 4..63 at indices 0..59; read returns 0..63 in order.
- Read len 7 with `i_rready` toggled pseudo-randomly -> exactly 8 beats in address order, none duplicated or dropped, `o_rdata` stable during stalls.
- `i_wcmd_valid` and `i_rcmd_valid` both held high with the same address from reset -> write granted first, then read, alternating; each read returns the immediately preceding write's data.
- Reset asserted at beat 3 of an 8-beat read -> next cycle `o_rvalid` = 0, `o_busy` = 0, `o_*cmd_ready` = 0 until deassert; a fresh command after reset is served normally.
- Write beats with `i_wvalid` gaps of 0–5 cycles, len 15 -> all 16 words written correctly; command readies stay 0 until the 16th beat completes.
